// File: rtl/uart_transceiver_param_pkg.sv
// Shared UART types: parity modes, TX/RX FSM states, baud divider helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Clocks per oversample tick, rounded down and never below one.
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_transceiver_param_if.sv
// Bus-side and line-side signals of the UART transceiver.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while tx_busy is low.
interface uart_transceiver_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] data_tx_in;
    logic                 tx_busy;
    logic                 tx_out;
    logic                 rx_in;
    logic                 loopback;
    logic                 ok_data_rx;
    logic [DATA_BITS-1:0] data_rx_out;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output start, data_tx_in, rx_in, loopback,
        input  tx_busy, tx_out, ok_data_rx, data_rx_out, parity_err, frame_err
    );

    modport slave (
        input  start, data_tx_in, rx_in, loopback,
        output tx_busy, tx_out, ok_data_rx, data_rx_out, parity_err, frame_err
    );
endinterface

// File: rtl/uart_transceiver_param_baud_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks.
// Latency: first tick DIV clocks after reset release.
// Backpressure: none; tick runs regardless of consumers.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Wrap the counter at DIV-1 so the tick period is exactly DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/uart_transceiver_param.sv
// UART TX + oversampled RX sharing one baud tick; parity, framing check, loopback.
// Latency: TX line moves the edge after acceptance; RX delivers at the first stop-bit sample (+2 clk sync).
// Backpressure: start ignored (not queued) while tx_busy; RX has no stall, each frame overwrites the last.
module uart_transceiver_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_transceiver_param_if.slave bus
);
    localparam int            DIV       = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY != PAR_NONE);
    localparam logic          PAR_INV   = (PARITY == PAR_ODD);

    logic tick;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_state_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_par, tx_par_nxt;
    logic [3:0]           tx_bit, tx_bit_nxt;
    logic [TW-1:0]        tx_tick, tx_tick_nxt;
    logic                 tx_bit_end;
    logic                 tx_line;

    assign tx_bit_end = tick && (tx_tick == TICK_LAST);

    // TX state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_bit   <= '0;
            tx_tick  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_tick  <= tx_tick_nxt;
        end
    end

    // TX sequencing: each bit lasts OVERSAMPLE ticks; acceptance only from IDLE.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_bit_nxt   = tx_bit;
        tx_tick_nxt  = tx_tick;
        if (tx_state != TX_IDLE && tick)
            tx_tick_nxt = tx_bit_end ? '0 : tx_tick + TW'(1);
        case (tx_state)
            TX_IDLE: begin
                if (bus.start) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = bus.data_tx_in;
                    tx_par_nxt   = (^bus.data_tx_in) ^ PAR_INV;
                    tx_bit_nxt   = '0;
                    tx_tick_nxt  = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end)
                    tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_bit == DATA_LAST) begin
                        tx_bit_nxt   = '0;
                        tx_state_nxt = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end)
                    tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit == STOP_LAST) begin
                        tx_bit_nxt   = '0;
                        tx_state_nxt = TX_IDLE;
                    end else begin
                        tx_bit_nxt = tx_bit + 4'd1;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Line level is a pure function of the registered TX state.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
            TX_PARITY: tx_line = tx_par;
            default:   tx_line = 1'b1;
        endcase
    end

    assign bus.tx_busy = (tx_state != TX_IDLE);
    assign bus.tx_out  = bus.loopback ? 1'b1 : tx_line;

    // ---------------- receiver ----------------
    logic                 rx_line;
    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state, rx_state_nxt;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
    logic                 rx_par, rx_par_nxt;
    logic [3:0]           rx_bit, rx_bit_nxt;
    logic [TW-1:0]        rx_tick, rx_tick_nxt;
    logic [DATA_BITS-1:0] rx_data, rx_data_nxt;
    logic                 rx_perr, rx_perr_nxt;
    logic                 rx_ferr, rx_ferr_nxt;
    logic                 rx_ok, rx_ok_nxt;
    logic                 rx_sample;

    assign rx_line   = bus.loopback ? tx_line : bus.rx_in;
    assign rx_s      = rx_sync[1];
    assign rx_sample = tick && (rx_tick == ((rx_state == RX_START) ? TICK_HALF : TICK_LAST));

    // Two-flop synchroniser; resets to idle-high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], rx_line};
    end

    // RX state, shift register and delivered-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_par   <= 1'b0;
            rx_bit   <= '0;
            rx_tick  <= '0;
            rx_data  <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ok    <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_shift <= rx_shift_nxt;
            rx_par   <= rx_par_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_tick  <= rx_tick_nxt;
            rx_data  <= rx_data_nxt;
            rx_perr  <= rx_perr_nxt;
            rx_ferr  <= rx_ferr_nxt;
            rx_ok    <= rx_ok_nxt;
        end
    end

    // RX sequencing: half-bit to mid-start, then one sample per bit; deliver on first stop sample.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_shift_nxt = rx_shift;
        rx_par_nxt   = rx_par;
        rx_bit_nxt   = rx_bit;
        rx_tick_nxt  = rx_tick;
        rx_data_nxt  = rx_data;
        rx_perr_nxt  = rx_perr;
        rx_ferr_nxt  = rx_ferr;
        rx_ok_nxt    = 1'b0;
        if (tick && (rx_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}))
            rx_tick_nxt = rx_sample ? '0 : rx_tick + TW'(1);
        case (rx_state)
            RX_IDLE: begin
                if (tick && !rx_s) begin
                    rx_state_nxt = RX_START;
                    rx_tick_nxt  = '0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    // A high line at mid-start is a glitch, not a frame.
                    if (rx_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_bit_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == DATA_LAST) begin
                        rx_bit_nxt   = '0;
                        rx_state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_nxt   = rx_s;
                    rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_data_nxt  = rx_shift;
                    rx_perr_nxt  = PAR_EN & (rx_par ^ (^rx_shift) ^ PAR_INV);
                    rx_ferr_nxt  = ~rx_s;
                    rx_ok_nxt    = 1'b1;
                    // A low stop bit may be a break; wait for idle before hunting again.
                    rx_state_nxt = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (tick && rx_s)
                    rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign bus.ok_data_rx  = rx_ok;
    assign bus.data_rx_out = rx_data;
    assign bus.parity_err  = rx_perr;
    assign bus.frame_err   = rx_ferr;
endmodule
